// File: rtl/led_ring_pkg.sv
// rtl/led_ring_pkg.sv - shared types and widths for the LED ring frame scheduler
package led_ring_pkg;

    localparam int NUM_LEDS = 12;
    localparam int COLOUR_W = 3;
    localparam int INTEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        HOLDOFF   = 2'd3
    } state_t;

    typedef struct packed {
        logic [NUM_LEDS-1:0] mask;
        logic [COLOUR_W-1:0] colour;
        logic [INTEN_W-1:0]  intensity;
    } frame_t;

endpackage

// File: rtl/led_ring_scheduler_if.sv
// rtl/led_ring_scheduler_if.sv - one frame requester's request/data/ack bundle
interface led_ring_scheduler_if;
    import led_ring_pkg::*;

    logic                req;
    logic [NUM_LEDS-1:0] mask;
    logic [COLOUR_W-1:0] colour;
    logic [INTEN_W-1:0]  inten;
    logic                ack;

    modport master (output req, mask, colour, inten, input ack);
    modport slave  (input req, mask, colour, inten, output ack);

endinterface

// File: rtl/led_ring_rr_arb.sv
// rtl/led_ring_rr_arb.sv - 2-way round-robin arbiter; bit 0 = A, bit 1 = B
module led_ring_rr_arb (
    input  logic       clk,
    input  logic       res,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // Reset to "B granted last" so A wins the first tie
    logic last_b;

    always_ff @(posedge clk) begin
        if (res) begin
            last_b <= 1'b1;
        end else if (update) begin
            last_b <= grant[1];
        end
    end

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_b ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/led_ring_scheduler.sv
// rtl/led_ring_scheduler.sv - arbitrates two frame requesters onto one ring driver
// Optional: LED_RING_SCHED_DIM_EN adds a dim[1:0] input that right-shifts the intensity at grant.
module led_ring_scheduler
    import led_ring_pkg::*;
#(
    parameter int MIN_GAP     = 4000,
    parameter int ACK_TIMEOUT = 64,
    parameter int GAP_W       = 12
) (
    input  logic                 clk,
    input  logic                 res,
    led_ring_scheduler_if.slave  src_a,
    led_ring_scheduler_if.slave  src_b,
`ifdef LED_RING_SCHED_DIM_EN
    input  logic [1:0]           dim,
`endif
    output logic                 drv_refresh,
    output logic [NUM_LEDS-1:0]  drv_led_mask,
    output logic [COLOUR_W-1:0]  drv_colour,
    output logic [INTEN_W-1:0]   drv_intensity,
    input  logic                 drv_busy,
    output logic                 sched_busy,
    output logic                 err_timeout
);

    state_t           state, state_n;
    logic [GAP_W-1:0] cnt, cnt_n;
    frame_t           frame_q, frame_n, frame_sel;
    logic             refresh_n, ack_a_q, ack_a_n, ack_b_q, ack_b_n;
    logic             busy_n, err_n, grant_en;
    logic [1:0]       gnt;

    led_ring_rr_arb u_arb (
        .clk    (clk),
        .res    (res),
        .req    ({src_b.req, src_a.req}),
        .update (grant_en),
        .grant  (gnt)
    );

    always_comb begin
        frame_sel = gnt[0] ? frame_t'{src_a.mask, src_a.colour, src_a.inten}
                           : frame_t'{src_b.mask, src_b.colour, src_b.inten};
`ifdef LED_RING_SCHED_DIM_EN
        frame_sel.intensity = frame_sel.intensity >> dim;
`endif
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        frame_n   = frame_q;
        refresh_n = drv_refresh;
        err_n     = err_timeout;
        ack_a_n   = 1'b0;
        ack_b_n   = 1'b0;
        grant_en  = 1'b0;
        case (state)
            IDLE: begin
                if (gnt != 2'b00) begin
                    grant_en  = 1'b1;
                    frame_n   = frame_sel;
                    refresh_n = 1'b1;
                    ack_a_n   = gnt[0];
                    ack_b_n   = gnt[1];
                    cnt_n     = '0;
                    state_n   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n = cnt + 1'b1;
                if (drv_busy) begin
                    refresh_n = 1'b0;
                    state_n   = WAIT_DONE;
                end else if (cnt == GAP_W'(ACK_TIMEOUT - 1)) begin
                    refresh_n = 1'b0;
                    err_n     = 1'b1;
                    cnt_n     = '0;
                    state_n   = HOLDOFF;
                end
            end
            WAIT_DONE: begin
                if (!drv_busy) begin
                    cnt_n   = '0;
                    state_n = HOLDOFF;
                end
            end
            HOLDOFF: begin
                cnt_n = cnt + 1'b1;
                if (cnt == GAP_W'(MIN_GAP - 1)) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Registered copy of "not IDLE" so sched_busy tracks state exactly
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state       <= IDLE;
            cnt         <= '0;
            frame_q     <= '0;
            drv_refresh <= 1'b0;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            sched_busy  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            frame_q     <= frame_n;
            drv_refresh <= refresh_n;
            ack_a_q     <= ack_a_n;
            ack_b_q     <= ack_b_n;
            sched_busy  <= busy_n;
            err_timeout <= err_n;
        end
    end

    assign src_a.ack     = ack_a_q;
    assign src_b.ack     = ack_b_q;
    assign drv_led_mask  = frame_q.mask;
    assign drv_colour    = frame_q.colour;
    assign drv_intensity = frame_q.intensity;

endmodule
